// File: rtl/fwd_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_pkg
// Shared definitions for the EX-stage forwarding / hazard controller.
//   sel_e        : operand-mux select codes (regfile, EX/MEM, MEM/WB, imm)
//   TAG_FLAG_W   : number of flag bits in a pipeline tag {valid,reg_write,mem_read}
//   TAG_DST_LSB  : bit offset of the destination index inside a tag
//   tagWidth()   : full tag width for a given register-index width
// Tag layout (MSB..LSB): valid | reg_write | mem_read | dst[REG_W-1:0]
// ---------------------------------------------------------------------------
package fwd_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    SEL_REGFILE = 2'b00,
    SEL_EXMEM   = 2'b01,
    SEL_MEMWB   = 2'b10,
    SEL_IMM     = 2'b11
  } sel_e;

  localparam int TAG_FLAG_W  = 3;
  localparam int TAG_DST_LSB = 0;

  function automatic int tagWidth(input int regW);
    return regW + TAG_FLAG_W;
  endfunction

endpackage

// File: rtl/fwd_tag_stage.sv
// ---------------------------------------------------------------------------
// fwd_tag_stage
// One pipeline tag register (used for the EX, MEM and WB tag stages).
// An all-zero tag is a bubble: its valid bit is clear, so it never matches.
// Ports:
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous, active-high; clears the tag
//   i_bubble  in   1   load a bubble instead of i_tag
//   i_tag     in   W   tag from the previous stage
//   o_tag     out  W   registered tag
// ---------------------------------------------------------------------------
module fwd_tag_stage
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int W = tagWidth(5)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_bubble,
  input  logic [W-1:0] i_tag,
  output logic [W-1:0] o_tag
);

  logic [W-1:0] r_tag;

  // Tag register: reset and bubble both load an invalid (all-zero) tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag <= '0;
    end else if (i_bubble) begin
      r_tag <= '0;
    end else begin
      r_tag <= i_tag;
    end
  end

  assign o_tag = r_tag;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding / hazard control for the EX-stage 4:1 operand muxes. Tracks the
// destination tags of in-flight instructions (EX, MEM, WB), produces
// registered operand selects aligned with the instruction entering EX, and
// raises a combinational stall on a load-use hazard. A taken-branch flush
// squashes the ID instruction into a bubble and overrides any stall.
//
// Optional feature macro: STALL_COUNT_EN
//   defined   -> stall_count port present; saturating count of stall cycles
//   undefined -> stall_count port and counter absent
//
// Ports:
//   clk           in   1      rising-edge clock
//   reset         in   1      synchronous, active-high
//   id_valid      in   1      ID holds a real instruction
//   id_rs         in   REG_W  source A index
//   id_rt         in   REG_W  source B index
//   id_dst        in   REG_W  destination index
//   id_reg_write  in   1      instruction writes id_dst
//   id_mem_read   in   1      instruction is a load
//   id_use_imm    in   1      operand B is the immediate
//   flush         in   1      squash the ID instruction
//   stall         out  1      hold PC/IF-ID (combinational)
//   sel_a         out  2      EX operand-A select (registered, never 11)
//   sel_b         out  2      EX operand-B select (registered)
//   stall_count   out  CNT_W  stall cycles since reset (STALL_COUNT_EN only)
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_use_imm,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b
`ifdef STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  localparam int TAG_W     = tagWidth(REG_W);
  localparam int MR_BIT    = TAG_DST_LSB + REG_W;
  localparam int RW_BIT    = MR_BIT + 1;
  localparam int VALID_BIT = RW_BIT + 1;

  logic [TAG_W-1:0] w_idTag;
  logic [TAG_W-1:0] w_exT;
  logic [TAG_W-1:0] w_memT;
  logic [TAG_W-1:0] w_wbT;
  logic             w_bubbleEx;
  logic             w_unusedWb;
  sel_e             w_selANext;
  sel_e             w_selBNext;
  sel_e             r_selA;
  sel_e             w_selBReg;
  sel_e             r_selB;

  // A stage supplies register r only if it holds a real, writing instruction;
  // r0 is hard-wired zero and is never forwarded.
  function automatic logic hit(input logic [TAG_W-1:0] t, input logic [REG_W-1:0] r);
    return t[VALID_BIT] & t[RW_BIT] & (t[TAG_DST_LSB +: REG_W] == r) & (r != '0);
  endfunction

  // The youngest producer (EX) wins over MEM; WB is covered by the
  // write-first register file, so it maps to the regfile path.
  function automatic sel_e fwdSel(input logic [TAG_W-1:0] exT,
                                  input logic [TAG_W-1:0] memT,
                                  input logic [REG_W-1:0] r);
    if (hit(exT, r)) begin
      return SEL_EXMEM;
    end else if (hit(memT, r)) begin
      return SEL_MEMWB;
    end
    return SEL_REGFILE;
  endfunction

  assign w_idTag = {id_valid, id_reg_write, id_mem_read, id_dst};

  // A load still in EX has no data yet; operand B only counts when it is
  // a register. A flush removes the consumer, so it suppresses the stall.
  assign stall = id_valid & ~flush & w_exT[MR_BIT] &
                 (hit(w_exT, id_rs) | (hit(w_exT, id_rt) & ~id_use_imm));

  assign w_bubbleEx = flush | stall;

  fwd_tag_stage #(.W(TAG_W)) u_exStage (
    .clk      (clk),
    .reset    (reset),
    .i_bubble (w_bubbleEx),
    .i_tag    (w_idTag),
    .o_tag    (w_exT)
  );

  fwd_tag_stage #(.W(TAG_W)) u_memStage (
    .clk      (clk),
    .reset    (reset),
    .i_bubble (1'b0),
    .i_tag    (w_exT),
    .o_tag    (w_memT)
  );

  fwd_tag_stage #(.W(TAG_W)) u_wbStage (
    .clk      (clk),
    .reset    (reset),
    .i_bubble (1'b0),
    .i_tag    (w_memT),
    .o_tag    (w_wbT)
  );

  // WB is tracked for completeness but never forwarded from.
  assign w_unusedWb = ^w_wbT;

  // Next selects for the instruction about to enter EX. An invalid ID slot
  // behaves as a bubble, but still steers operand B to the immediate.
  always_comb begin
    w_selANext = SEL_REGFILE;
    w_selBReg  = SEL_REGFILE;
    if (id_valid) begin
      w_selANext = fwdSel(w_exT, w_memT, id_rs);
      w_selBReg  = fwdSel(w_exT, w_memT, id_rt);
    end
    w_selBNext = id_use_imm ? SEL_IMM : w_selBReg;
  end

  // Select registers move with the instruction into EX; a bubble gets 00.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_selA <= SEL_REGFILE;
      r_selB <= SEL_REGFILE;
    end else if (w_bubbleEx) begin
      r_selA <= SEL_REGFILE;
      r_selB <= SEL_REGFILE;
    end else begin
      r_selA <= w_selANext;
      r_selB <= w_selBNext;
    end
  end

  assign sel_a = r_selA;
  assign sel_b = r_selB;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] r_stallCount;

  // Saturating stall-cycle counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCount <= '0;
    end else if (stall && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + 1'b1;
    end
  end

  assign stall_count = r_stallCount;
`else
  logic [CNT_W-1:0] w_unusedCnt;
  assign w_unusedCnt = '0;
`endif

endmodule
